// File: rtl/regbank_pkg.sv
// Shared types and helpers for the register-bank access controller.
package regbank_pkg;

    localparam int DATA_W = 32;

    typedef enum logic {
        OP_WRITE     = 1'b0,
        OP_FETCH_ADD = 1'b1
    } op_e;

    typedef enum logic [1:0] {
        IDLE,
        EXEC,
        RESP
    } state_e;

    // Value committed to the register for a given op; FETCH_ADD wraps modulo 2^32.
    function automatic logic [DATA_W-1:0] apply_op(
        input op_e               op,
        input logic [DATA_W-1:0] old_val,
        input logic [DATA_W-1:0] operand
    );
        return (op == OP_FETCH_ADD) ? old_val + operand : operand;
    endfunction

endpackage

// File: rtl/regbank_access_ctrl_rr_arbiter.sv
// Combinational round-robin arbiter: grants the first requester at or after ptr,
// wrapping to the lowest index. The pointer register lives in the parent.
module rr_arbiter #(
    parameter  int N  = 4,
    localparam int IW = (N > 1) ? $clog2(N) : 1
) (
    input  logic [N-1:0]  req,
    input  logic [IW-1:0] ptr,
    output logic [N-1:0]  gnt,
    output logic [IW-1:0] gnt_idx,
    output logic          any
);

    logic [N-1:0] upper;
    logic [N-1:0] pick;

    always_comb begin
        upper = '0;
        for (int i = 0; i < N; i++) begin
            upper[i] = req[i] && (i >= int'(ptr));
        end
    end

    // Requests at or above the pointer take priority; otherwise wrap to the bottom.
    assign pick = (|upper) ? upper : req;
    assign any  = |req;

    always_comb begin
        // NOTE: outputs get defaults before the loop so every path assigns them and no latch is inferred.
        gnt     = '0;
        gnt_idx = '0;
        for (int i = N - 1; i >= 0; i--) begin
            if (pick[i]) begin
                gnt     = '0;
                gnt[i]  = 1'b1;
                gnt_idx = IW'(i);
            end
        end
    end

endmodule

// File: rtl/regbank_access_ctrl.sv
// Register bank with a single round-robin-arbitrated write/fetch-add port and
// a combinational read port; one operation in flight at a time.
module regbank_access_ctrl
    import regbank_pkg::*;
#(
    parameter  int NREQ  = 4,
    parameter  int NREGS = 8,
    localparam int AW    = $clog2(NREGS),
    localparam int IW    = $clog2(NREQ)
) (
    input  logic                   clk,
    input  logic                   rst,
    input  logic [NREQ-1:0]        req_valid,
    output logic [NREQ-1:0]        req_ready,
    input  logic [NREQ-1:0]        req_op,
    input  logic [NREQ*AW-1:0]     req_addr,
    input  logic [NREQ*DATA_W-1:0] req_data,
    output logic                   rsp_valid,
    input  logic                   rsp_ready,
    output logic [IW-1:0]          rsp_id,
    output logic [DATA_W-1:0]      rsp_data,
    output logic                   rsp_err,
    input  logic [AW-1:0]          rd_addr,
    output logic [DATA_W-1:0]      rd_data
);

    localparam logic [AW:0] NREGS_W = (AW + 1)'(NREGS);

    state_e              state, state_nxt;
    logic [IW-1:0]       ptr;
    op_e                 op_q;
    logic [AW-1:0]       addr_q;
    logic [DATA_W-1:0]   data_q;
    logic [IW-1:0]       id_q;
    logic [DATA_W-1:0]   rsp_data_q;
    logic                rsp_err_q;
    logic [DATA_W-1:0]   bank [NREGS];

    logic [AW-1:0]       addr_arr [NREQ];
    logic [DATA_W-1:0]  data_arr [NREQ];
    logic [NREQ-1:0]     arb_gnt;
    logic [IW-1:0]       arb_gnt_idx;
    logic                arb_any;
    logic                accept;
    logic                addr_ok;
    logic [IW-1:0]       ptr_nxt;

    for (genvar g = 0; g < NREQ; g++) begin : g_unpack
        assign addr_arr[g] = req_addr[g*AW +: AW];
        assign data_arr[g] = req_data[g*DATA_W +: DATA_W];
    end

    rr_arbiter #(.N(NREQ)) u_arb (
        .req     (req_valid),
        .ptr     (ptr),
        .gnt     (arb_gnt),
        .gnt_idx (arb_gnt_idx),
        .any     (arb_any)
    );

    assign accept  = (state == IDLE) && arb_any;
    assign ptr_nxt = (arb_gnt_idx == IW'(NREQ - 1)) ? '0 : arb_gnt_idx + 1'b1;
    // Always true for a power-of-two bank; kept so a non-power-of-two bank cannot index past the end.
    assign addr_ok = {1'b0, addr_q} < NREGS_W;

    always_comb begin
        state_nxt = state;
        req_ready = '0;
        unique case (state)
            IDLE: begin
                if (arb_any) begin
                    req_ready = arb_gnt;
                    state_nxt = EXEC;
                end
            end
            EXEC:    state_nxt = RESP;
            RESP:    if (rsp_ready) state_nxt = IDLE;
            default: state_nxt = IDLE;
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state  <= IDLE;
            ptr    <= '0;
            op_q   <= OP_WRITE;
            addr_q <= '0;
            data_q <= '0;
            id_q   <= '0;
        end else begin
            // NOTE: sequential state uses non-blocking assignments so every flop samples pre-edge values.
            state <= state_nxt;
            if (accept) begin
                op_q   <= op_e'(req_op[arb_gnt_idx]);
                addr_q <= addr_arr[arb_gnt_idx];
                data_q <= data_arr[arb_gnt_idx];
                id_q   <= arb_gnt_idx;
                ptr    <= ptr_nxt;
            end
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            // NOTE: the bank lives in flops so reset can clear it; a RAM macro could not honour this.
            for (int i = 0; i < NREGS; i++) begin
                bank[i] <= '0;
            end
            rsp_data_q <= '0;
            rsp_err_q  <= 1'b0;
        end else if (state == EXEC) begin
            if (addr_ok) begin
                rsp_data_q   <= bank[addr_q];
                rsp_err_q    <= 1'b0;
                bank[addr_q] <= apply_op(op_q, bank[addr_q], data_q);
            end else begin
                rsp_data_q <= '0;
                rsp_err_q  <= 1'b1;
            end
        end
    end

    assign rsp_valid = (state == RESP);
    assign rsp_id    = id_q;
    assign rsp_data  = rsp_data_q;
    assign rsp_err   = rsp_err_q;
    assign rd_data   = bank[rd_addr];

endmodule

// File: tb/tb_regbank_access_ctrl.sv
// Self-checking bench for regbank_access_ctrl: transaction-level reference model
// checked every cycle, directed scenarios with literal expectations, then random traffic.
module tb_regbank_access_ctrl;
    import regbank_pkg::*;

    localparam int NREQ  = 4;
    localparam int NREGS = 8;
    localparam int AW    = $clog2(NREGS);
    localparam int IW    = $clog2(NREQ);

    logic                clk = 1'b0;
    logic                rst;
    logic [NREQ-1:0]     req_valid;
    logic [NREQ-1:0]     req_ready;
    logic [NREQ-1:0]     req_op;
    logic [NREQ*AW-1:0]  req_addr;
    logic [NREQ*32-1:0]  req_data;
    logic                rsp_valid;
    logic                rsp_ready;
    logic [IW-1:0]       rsp_id;
    logic [31:0]         rsp_data;
    logic                rsp_err;
    logic [AW-1:0]       rd_addr;
    logic [31:0]         rd_data;

    regbank_access_ctrl #(.NREQ(NREQ), .NREGS(NREGS)) dut (
        .clk       (clk),
        .rst       (rst),
        .req_valid (req_valid),
        .req_ready (req_ready),
        .req_op    (req_op),
        .req_addr  (req_addr),
        .req_data  (req_data),
        .rsp_valid (rsp_valid),
        .rsp_ready (rsp_ready),
        .rsp_id    (rsp_id),
        .rsp_data  (rsp_data),
        .rsp_err   (rsp_err),
        .rd_addr   (rd_addr),
        .rd_data   (rd_data)
    );

    always #5 clk = ~clk;

    typedef struct {
        int          id;
        logic [31:0] data;
        logic        err;
    } rsp_t;

    int          total = 0;
    int          bad   = 0;
    rsp_t        rsp_log [$];
    logic [NREQ-1:0] acc;

    // Reference model: committed bank contents plus the one operation in flight.
    logic [31:0] m_bank [NREGS];
    int          m_ptr;
    int          m_age;      // -1 idle, 0 = cycle after accept, >=1 response offered
    int          m_id;
    int          m_addr;
    logic [31:0] m_old;
    logic [31:0] m_new;
    logic        m_err;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got 0x%08h expected 0x%08h (t=%0t)", name, act, exp, $time);
        end
    endtask

    function automatic int m_winner(input logic [NREQ-1:0] v, input int p);
        for (int k = 0; k < NREQ; k++) begin
            if (v[(p + k) % NREQ]) return (p + k) % NREQ;
        end
        return -1;
    endfunction

    task automatic m_reset();
        for (int i = 0; i < NREGS; i++) m_bank[i] = '0;
        m_ptr = 0;
        m_age = -1;
    endtask

    // Compare process: every cycle, checks outputs at the falling edge, then advances the model.
    initial begin : compare
        int              w;
        logic [NREQ-1:0] exp_ready;
        m_reset();
        acc = '0;
        forever begin
            @(negedge clk);
            if (rst) begin
                acc = '0;
                m_reset();
                check("rst_req_ready", 32'(req_ready), 32'h0);
                check("rst_rsp_valid", 32'(rsp_valid), 32'h0);
                check("rst_rsp_id",    32'(rsp_id),    32'h0);
                check("rst_rsp_data",  rsp_data,       32'h0);
                check("rst_rsp_err",   32'(rsp_err),   32'h0);
                check("rst_rd_data",   rd_data,        32'h0);
                continue;
            end
            acc = req_valid & req_ready;
            check("rd_data", rd_data, m_bank[rd_addr]);
            if (m_age < 0) begin
                w = m_winner(req_valid, m_ptr);
                exp_ready = '0;
                if (w >= 0) exp_ready[w] = 1'b1;
                check("req_ready_idle", 32'(req_ready), 32'(exp_ready));
                check("rsp_valid_idle", 32'(rsp_valid), 32'h0);
                if (w >= 0) begin
                    m_id   = w;
                    m_addr = int'(req_addr[w*AW +: AW]);
                    m_err  = (m_addr >= NREGS);
                    m_old  = m_err ? 32'h0 : m_bank[m_addr];
                    m_new  = req_op[w] ? m_old + req_data[w*32 +: 32] : req_data[w*32 +: 32];
                    m_ptr  = (w + 1) % NREQ;
                    m_age  = 0;
                end
            end else if (m_age == 0) begin
                check("req_ready_exec", 32'(req_ready), 32'h0);
                check("rsp_valid_exec", 32'(rsp_valid), 32'h0);
                if (!m_err) m_bank[m_addr] = m_new;
                m_age = 1;
            end else begin
                check("req_ready_resp", 32'(req_ready), 32'h0);
                check("rsp_valid_resp", 32'(rsp_valid), 32'h1);
                check("rsp_id",         32'(rsp_id),    32'(m_id));
                check("rsp_data",       rsp_data,       m_old);
                check("rsp_err",        32'(rsp_err),   32'(m_err));
                m_age++;
                if (rsp_ready) begin
                    rsp_log.push_back('{id: int'(rsp_id), data: rsp_data, err: rsp_err});
                    m_age = -1;
                end
            end
        end
    end

    task automatic set_req(input int id, input logic op, input int addr, input logic [31:0] data);
        req_valid[id]          = 1'b1;
        req_op[id]             = op;
        req_addr[id*AW +: AW]  = AW'(addr);
        req_data[id*32 +: 32]  = data;
    endtask

    // Advance one cycle; requesters drop valid once accepted, optionally new random requests appear.
    task automatic step(input bit rnd);
        @(posedge clk);
        #1;
        req_valid = req_valid & ~acc;
        if (rnd) begin
            for (int i = 0; i < NREQ; i++) begin
                if (!req_valid[i] && $urandom_range(0, 2) == 0) begin
                    set_req(i, 1'($urandom_range(0, 1)), int'($urandom_range(0, NREGS - 1)),
                            ($urandom_range(0, 3) == 0) ? 32'hFFFF_FFF0 + 32'($urandom_range(0, 31))
                                                         : $urandom);
                end
            end
            rsp_ready = ($urandom_range(0, 3) != 0);
            rd_addr   = AW'($urandom_range(0, NREGS - 1));
        end
    endtask

    task automatic wait_rsps(input int target, input int budget, input string name);
        for (int c = 0; c < budget && rsp_log.size() < target; c++) step(0);
        check(name, 32'(rsp_log.size() >= target), 32'h1);
    endtask

    task automatic do_op(input int id, input logic op, input int addr, input logic [31:0] data,
                         output rsp_t r);
        int n0;
        n0 = rsp_log.size();
        set_req(id, op, addr, data);
        rsp_ready = 1'b1;
        wait_rsps(n0 + 1, 30, "op_complete");
        if (rsp_log.size() > n0) r = rsp_log[n0];
        else r = '{id: -1, data: 32'hFFFF_FFFF, err: 1'b1};
    endtask

    initial begin : watchdog
        #500000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1);
    end

    initial begin : stimulus
        rsp_t r;
        int   n0;
        rst       = 1'b1;
        req_valid = '0;
        req_op    = '0;
        req_addr  = '0;
        req_data  = '0;
        rsp_ready = 1'b0;
        rd_addr   = '0;
        repeat (3) @(posedge clk);
        #1 rst = 1'b0;

        // WRITE 0xDEADBEEF to reg 3 from requester 0, cycle by cycle.
        rd_addr = 3;
        set_req(0, OP_WRITE, 3, 32'hDEAD_BEEF);
        rsp_ready = 1'b1;
        @(negedge clk);
        check("t1_ready_pulse", 32'(req_ready), 32'h1);
        check("t1_rd_before",   rd_data,        32'h0);
        step(0);
        @(negedge clk);
        check("t1_ready_exec",  32'(req_ready), 32'h0);
        check("t1_valid_exec",  32'(rsp_valid), 32'h0);
        check("t1_rd_exec",     rd_data,        32'h0);
        step(0);
        @(negedge clk);
        check("t1_rsp_valid",   32'(rsp_valid), 32'h1);
        check("t1_rsp_id",      32'(rsp_id),    32'h0);
        check("t1_rsp_data",    rsp_data,       32'h0);
        check("t1_rsp_err",     32'(rsp_err),   32'h0);
        check("t1_rd_after",    rd_data,        32'hDEAD_BEEF);
        step(0);

        // FETCH_ADD wraps past 2^32.
        do_op(2, OP_WRITE, 5, 32'hFFFF_FFF0, r);
        do_op(2, OP_FETCH_ADD, 5, 32'h20, r);
        check("t2_rsp_id",   32'(r.id), 32'h2);
        check("t2_rsp_data", r.data,    32'hFFFF_FFF0);
        check("t2_rsp_err",  32'(r.err), 32'h0);
        rd_addr = 5;
        @(negedge clk);
        check("t2_reg5_wrap", rd_data, 32'h10);
        step(0);

        // Lone requester 3, then lone requester 1 found by the wrapped scan.
        do_op(3, OP_WRITE, 6, 32'h66, r);
        check("t6_first_id", 32'(r.id), 32'h3);
        do_op(1, OP_WRITE, 7, 32'h77, r);
        check("t6_second_id", 32'(r.id), 32'h1);
        do_op(3, OP_WRITE, 6, 32'h600, r);
        check("t6_third_id", 32'(r.id), 32'h3);

        // All four FETCH_ADD 1 to reg 0 with the pointer at 0.
        n0 = rsp_log.size();
        for (int i = 0; i < NREQ; i++) set_req(i, OP_FETCH_ADD, 0, 32'h1);
        wait_rsps(n0 + NREQ, 40, "t3_complete");
        for (int i = 0; i < NREQ; i++) begin
            if (rsp_log.size() > n0 + i) begin
                check("t3_grant_order", 32'(rsp_log[n0+i].id), 32'(i));
                check("t3_old_value",   rsp_log[n0+i].data,    32'(i));
            end
        end
        rd_addr = 0;
        @(negedge clk);
        check("t3_reg0_final", rd_data, 32'h4);
        step(0);

        // Back-pressure: response held 5 cycles while others wait.
        n0 = rsp_log.size();
        set_req(1, OP_WRITE, 2, 32'h55);
        rsp_ready = 1'b0;
        @(negedge clk);
        check("t4_grant1", 32'(req_ready), 32'h2);
        step(0);
        set_req(0, OP_FETCH_ADD, 4, 32'h1);
        set_req(2, OP_FETCH_ADD, 4, 32'h2);
        @(negedge clk);
        check("t4_ready_exec", 32'(req_ready), 32'h0);
        for (int k = 0; k < 5; k++) begin
            step(0);
            @(negedge clk);
            check("t4_hold_valid", 32'(rsp_valid), 32'h1);
            check("t4_hold_id",    32'(rsp_id),    32'h1);
            check("t4_hold_data",  rsp_data,       32'h0);
            check("t4_hold_ready", 32'(req_ready), 32'h0);
        end
        step(0);
        rsp_ready = 1'b1;
        @(negedge clk);
        check("t4_hs_valid", 32'(rsp_valid), 32'h1);
        step(0);
        @(negedge clk);
        check("t4_next_grant", 32'(req_ready), 32'h4);
        step(0);
        wait_rsps(n0 + 3, 30, "t4_complete");
        rd_addr = 4;
        @(negedge clk);
        check("t4_reg4", rd_data, 32'h3);
        step(0);

        // Reset asserted during EXEC of a WRITE to reg 1.
        rd_addr = 1;
        set_req(0, OP_WRITE, 1, 32'h1234);
        @(negedge clk);
        check("t5_grant", 32'(req_ready), 32'h1);
        step(0);
        rst = 1'b1;
        #1;
        check("t5_async_valid", 32'(rsp_valid), 32'h0);
        check("t5_async_ready", 32'(req_ready), 32'h0);
        check("t5_async_reg1",  rd_data,        32'h0);
        rd_addr = 3;
        #1;
        check("t5_async_reg3",  rd_data,        32'h0);
        step(0);
        step(0);
        rst = 1'b0;
        rd_addr = 1;
        for (int k = 0; k < 4; k++) begin
            step(0);
            @(negedge clk);
            check("t5_no_rsp", 32'(rsp_valid), 32'h0);
        end
        check("t5_reg1_zero", rd_data, 32'h0);

        // Random traffic against the model.
        repeat (3000) step(1);
        rsp_ready = 1'b1;
        for (int c = 0; c < 300 && (req_valid != '0 || m_age >= 0); c++) step(0);
        check("drain_done", 32'(req_valid == '0 && m_age < 0), 32'h1);
        for (int a = 0; a < NREGS; a++) begin
            rd_addr = AW'(a);
            step(0);
        end

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
